clk_enable_ctrl: RTL and testbench
==================================

// Module: clk_enable_ctrl
// PURPOSE
//  Drives clk_enable for the AND-type clock gate that feeds the core clock.
//  Board buttons select the mode: halt, single-step, free-run or fixed-length burst.
//  A halt request from debug/breakpoint logic stops the clock.
//  Sits beside the gate in the board top; runs on the ungated board clock.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  stable cycles required before a button level is accepted (20 ms @ 50 MHz)
//  SYNC_STAGES      2        synchroniser flops per button input (>=2)
//  BURST_W          16       width of burst_len and the burst down-counter
// PORTS
//  clk_in       in   1        board clock, ungated; all logic runs on it
//  rst_n        in   1        synchronous reset, active low
//  btn_step     in   1        async button: one gated cycle per press
//  btn_run      in   1        async button: toggles free-run / halt
//  btn_burst    in   1        async button: run burst_len gated cycles (macro only)
//  burst_len    in   BURST_W  burst length, sampled on the accepted burst press
//  halt_req     in   1        sync level from debug logic: forces HALT
//  clk_enable   out  1        to clock gate; changes only while clk_in is low
//  mode         out  2        current state: 0 HALT, 1 STEP, 2 RUN, 3 BURST
//  gated_cycles out  32       count of cycles with clk_enable=1; wraps at 2^32
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=HALT, clk_enable=0, gated_cycles=0, debouncers cleared.
//  The negedge retime flop also resets synchronously on rst_n.
//  Buttons: SYNC_STAGES sync -> debounce.
//   - The level is accepted after DEBOUNCE_CYCLES consecutive equal samples.
//   - A 0->1 transition of the accepted level gives a 1-cycle press pulse.
//   - Holding a button gives exactly one pulse.
//  FSM, updated at posedge:
//   - HALT -> RUN on run press if halt_req=0.
//   - HALT -> BURST on burst press if halt_req=0 and burst_len!=0; the counter loads burst_len.
//   - HALT -> STEP on step press. Allowed even with halt_req=1, so software can step past a breakpoint.
//   - Priority when presses coincide in HALT: run > burst > step.
//   - burst_len==0 leaves the FSM in HALT.
//   - STEP -> HALT unconditionally after one cycle.
//   - RUN -> HALT on run press or halt_req=1.
//   - BURST: the counter decrements each enabled cycle.
//   - BURST -> HALT after the cycle in which the counter is 1.
//   - A run press or halt_req aborts BURST -> HALT immediately. Other presses are ignored outside HALT.
//  Enable timing:
//   - en_q (posedge) = (next_state != HALT). en_q is retimed on negedge clk_in to form clk_enable.
//   - Consequently clk_enable is stable through every high phase and the gate output is glitch-free.
//   - A press pulse at posedge N gives the first gated rising edge at posedge N+1.
//   - STEP gives exactly 1 gated edge; BURST gives exactly burst_len gated edges.
//   - halt_req rising at posedge N: clk_enable low from negedge N; no gated edge at N+1.
//  gated_cycles increments at each posedge where clk_enable=1.
// CONFIGURATION
//  CLK_ENABLE_CTRL_BURST_EN defined:
//   - btn_burst, burst_len and BURST state are active.
//  CLK_ENABLE_CTRL_BURST_EN undefined:
//   - The btn_burst debouncer and burst counter are not built; ports stay but are ignored.
//   - mode never reads 3.
// STRUCTURE
//  Package clk_enable_ctrl_pkg:
//   - ctrl_state_t enum {HALT=0, STEP=1, RUN=2, BURST=3}.
//   - MODE_W=2 and CYCLE_CNT_W=32.
//  Sub-module btn_debounce (#SYNC_STAGES, DEBOUNCE_CYCLES):
//   - Ports: clk_in, rst_n, btn_async, level, press.
//   - One instance per button.
// TESTING  (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, BURST_W=8)
//  1. Reset, then idle 20 cycles -> clk_enable=0, mode=0, gated_cycles=0.
//  2. btn_step high 3 cycles, low -> no press. High 10 cycles -> exactly 1 gated cycle, mode back to 0, gated_cycles=1.
//  3. Run press -> clk_enable=1 continuously. halt_req=1 at cycle k -> mode=0, and clk_enable drops before the next high phase.
//  4. burst_len=5, burst press -> exactly 5 cycles with clk_enable=1, then HALT. burst_len=0 -> no enable.
//  5. Run and step pressed in the same cycle from HALT -> mode=2. Step with halt_req=1 held -> one gated cycle.
//  6. rst_n=0 mid-BURST -> next posedge: mode=0, gated_cycles=0. clk_enable low by the following negedge.
//     The macro-undefined build ignores the burst press.

Source files
------------

// File: rtl/clk_enable_ctrl_pkg.sv
// Shared state encoding and widths for the board clock-enable controller.
package clk_enable_ctrl_pkg;
  localparam int MODE_W      = 2;
  localparam int CYCLE_CNT_W = 32;

  typedef enum logic [MODE_W-1:0] {
    HALT  = 2'd0,
    STEP  = 2'd1,
    RUN   = 2'd2,
    BURST = 2'd3
  } ctrl_state_t;
endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser and debouncer.
// The output is a stable level plus a one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn_async,
  output logic level,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  // cnt counts consecutive synchronised samples that disagree with the accepted level
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_async};
      press  <= 1'b0;
      if (btn_s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= btn_s;
        press <= btn_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/clk_enable_ctrl.sv
// Clock-gate enable controller: halt / single-step / free-run / burst from board buttons.
// Burst mode (btn_burst, burst_len) is built only when CLK_ENABLE_CTRL_BURST_EN is defined.
module clk_enable_ctrl
  import clk_enable_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2,
  parameter int BURST_W         = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   btn_step,
  input  logic                   btn_run,
  input  logic                   btn_burst,
  input  logic [BURST_W-1:0]     burst_len,
  input  logic                   halt_req,
  output logic                   clk_enable,
  output logic [MODE_W-1:0]      mode,
  output logic [CYCLE_CNT_W-1:0] gated_cycles
);
  ctrl_state_t state, next_state;
  logic        en_q;
  logic        step_press, run_press, burst_press;
  logic        unused_step_level, unused_run_level;

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk_in(clk_in), .rst_n(rst_n), .btn_async(btn_step),
    .level(unused_step_level), .press(step_press)
  );

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk_in(clk_in), .rst_n(rst_n), .btn_async(btn_run),
    .level(unused_run_level), .press(run_press)
  );

`ifdef CLK_ENABLE_CTRL_BURST_EN
  logic               unused_burst_level;
  logic [BURST_W-1:0] burst_cnt;

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_burst_db (
    .clk_in(clk_in), .rst_n(rst_n), .btn_async(btn_burst),
    .level(unused_burst_level), .press(burst_press)
  );
`else
  logic unused_burst_in;

  assign unused_burst_in = ^{btn_burst, burst_len};
  assign burst_press     = 1'b0;
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      HALT: begin
        if (run_press && !halt_req)
          next_state = RUN;
`ifdef CLK_ENABLE_CTRL_BURST_EN
        else if (burst_press && !halt_req && (burst_len != '0))
          next_state = BURST;
`endif
        else if (step_press)
          next_state = STEP;
      end
      STEP: next_state = HALT;
      RUN:  if (run_press || halt_req) next_state = HALT;
      BURST: begin
`ifdef CLK_ENABLE_CTRL_BURST_EN
        if (run_press || halt_req || (burst_cnt == BURST_W'(1)))
          next_state = HALT;
`else
        next_state = HALT;
`endif
      end
      default: next_state = HALT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state <= HALT;
      en_q  <= 1'b0;
`ifdef CLK_ENABLE_CTRL_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      state <= next_state;
      en_q  <= (next_state != HALT);
`ifdef CLK_ENABLE_CTRL_BURST_EN
      if (state == HALT && next_state == BURST)
        burst_cnt <= burst_len;
      else if (state == BURST)
        burst_cnt <= burst_cnt - 1'b1;
`endif
    end
  end

  // Retiming on the falling edge keeps clk_enable stable through every high phase.
  always_ff @(negedge clk_in) begin
    if (!rst_n)
      clk_enable <= 1'b0;
    else
      clk_enable <= en_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n)
      gated_cycles <= '0;
    else if (clk_enable)
      gated_cycles <= gated_cycles + 1'b1;
  end

  assign mode = state;
endmodule

// File: tb/tb_clk_enable_ctrl.sv
module tb_clk_enable_ctrl;
  localparam int DB = 4;
  localparam int SS = 2;
  localparam int BW = 8;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_step = 1'b0, btn_run = 1'b0, btn_burst = 1'b0, halt_req = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic          clk_enable;
  logic [1:0]    mode;
  logic [31:0]   gated_cycles;

  always #5 clk_in = ~clk_in;

  clk_enable_ctrl #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS), .BURST_W(BW)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .btn_step(btn_step), .btn_run(btn_run),
    .btn_burst(btn_burst), .burst_len(burst_len), .halt_req(halt_req),
    .clk_enable(clk_enable), .mode(mode), .gated_cycles(gated_cycles)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each button is a stream of raw samples delayed by the
  // synchroniser; a level is accepted once the last DB seen samples agree.
  bit          hist_q[3][$];
  bit          win_q[3][$];
  bit          m_level[3];
  bit          m_press[3];
  int          m_mode = 0;   // 0 HALT, 1 STEP, 2 RUN, 3 BURST
  int          m_left = 0;   // gated edges still owed in burst
  logic [31:0] m_count = '0;
  bit          m_en = 1'b0;

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      hist_q[b] = {};
      for (int k = 0; k < SS; k++) hist_q[b].push_back(1'b0);
      win_q[b]   = {};
      m_level[b] = 1'b0;
      m_press[b] = 1'b0;
    end
    m_mode  = 0;
    m_left  = 0;
    m_count = '0;
  endtask

  task automatic model_posedge();
    bit raw[3];
    bit seen, same;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_en) m_count = m_count + 1;
    case (m_mode)
      0: begin
        if (m_press[1] && !halt_req) m_mode = 2;
        else if (m_press[2] && !halt_req && burst_len != 0) begin
          m_mode = 3;
          m_left = int'(burst_len);
        end else if (m_press[0]) m_mode = 1;
      end
      1: m_mode = 0;
      2: if (m_press[1] || halt_req) m_mode = 0;
      default: begin
        if (m_press[1] || halt_req) m_mode = 0;
        else begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end
    endcase
    raw[0] = btn_step;
    raw[1] = btn_run;
`ifdef CLK_ENABLE_CTRL_BURST_EN
    raw[2] = btn_burst;
`else
    raw[2] = 1'b0;
`endif
    for (int b = 0; b < 3; b++) begin
      seen = hist_q[b].pop_front();
      hist_q[b].push_back(raw[b]);
      win_q[b].push_back(seen);
      if (win_q[b].size() > DB) void'(win_q[b].pop_front());
      m_press[b] = 1'b0;
      same = (win_q[b].size() == DB);
      for (int k = 0; k < win_q[b].size(); k++)
        if (win_q[b][k] != seen) same = 1'b0;
      if (same && seen != m_level[b]) begin
        m_level[b] = seen;
        m_press[b] = seen;
      end
    end
  endtask

  task automatic tick();
    model_posedge();
    @(posedge clk_in);
    #1;
    check("mode", mode, m_mode);
    check("gated", gated_cycles, m_count);
    @(negedge clk_in);
    m_en = (m_mode != 0);
    #1;
    check("clk_en", {31'd0, clk_enable}, {31'd0, m_en});
  endtask

  task automatic hold(input bit s, input bit r, input bit b, input bit h, input int n);
    btn_step  = s;
    btn_run   = r;
    btn_burst = b;
    halt_req  = h;
    repeat (n) tick();
  endtask

  logic [31:0] m0;

  initial begin
    model_reset();
    rst_n = 1'b0;
    hold(0, 0, 0, 0, 3);
    rst_n = 1'b1;
    hold(0, 0, 0, 0, 20);
    check("reset_mode", mode, 0);
    check("reset_gated", gated_cycles, 0);
    check("reset_en", {31'd0, clk_enable}, 0);

    hold(1, 0, 0, 0, 3);
    hold(0, 0, 0, 0, 10);
    check("short_step_gated", gated_cycles, 0);
    hold(1, 0, 0, 0, 10);
    hold(0, 0, 0, 0, 20);
    check("step_gated", gated_cycles, 1);
    check("step_mode", mode, 0);

    hold(0, 1, 0, 0, 8);
    hold(0, 0, 0, 0, 6);
    check("run_mode", mode, 2);
    check("run_en", {31'd0, clk_enable}, 1);
    hold(0, 0, 0, 1, 1);
    check("halt_mode", mode, 0);
    check("halt_en", {31'd0, clk_enable}, 0);
    hold(0, 0, 0, 0, 2);

`ifdef CLK_ENABLE_CTRL_BURST_EN
    burst_len = 8'd5;
    m0 = m_count;
    hold(0, 0, 1, 0, 8);
    hold(0, 0, 0, 0, 20);
    check("burst5_gated", gated_cycles, m0 + 5);
    check("burst5_mode", mode, 0);
    burst_len = 8'd0;
    m0 = m_count;
    hold(0, 0, 1, 0, 8);
    hold(0, 0, 0, 0, 20);
    check("burst0_gated", gated_cycles, m0);
`else
    burst_len = 8'd5;
    m0 = m_count;
    hold(0, 0, 1, 0, 8);
    hold(0, 0, 0, 0, 20);
    check("burst_ignored_gated", gated_cycles, m0);
    check("burst_ignored_mode", mode, 0);
`endif

    hold(1, 1, 0, 0, 8);
    hold(0, 0, 0, 0, 6);
    check("run_over_step", mode, 2);
    hold(0, 1, 0, 0, 8);
    hold(0, 0, 0, 0, 12);
    check("run_toggle_off", mode, 0);

    m0 = m_count;
    hold(1, 0, 0, 1, 8);
    hold(0, 0, 0, 1, 12);
    check("step_past_halt", gated_cycles, m0 + 1);
    hold(0, 0, 0, 0, 2);

`ifdef CLK_ENABLE_CTRL_BURST_EN
    burst_len = 8'd200;
    hold(0, 0, 1, 0, 8);
    hold(0, 0, 0, 0, 10);
    check("long_burst_mode", mode, 3);
    rst_n = 1'b0;
    hold(0, 0, 0, 0, 1);
    check("rst_burst_mode", mode, 0);
    check("rst_burst_gated", gated_cycles, 0);
    check("rst_burst_en", {31'd0, clk_enable}, 0);
    rst_n = 1'b1;
    hold(0, 0, 0, 0, 4);
`endif

    for (int i = 0; i < 400; i++) begin
      burst_len = BW'($urandom_range(0, 9));
      rst_n     = ($urandom_range(0, 60) != 0);
      hold(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 7) == 0),
           $urandom_range(1, 12));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
